// File: rtl/constraint_pkg.sv
// Shared types for the constraint stream checker: opcodes, table entry layout, FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package constraint_pkg;

    localparam int DEF_NUM_VARS = 8;
    localparam int DEF_VAR_W    = 16;
    localparam int DEF_NUM_CONS = 16;
    localparam int DEF_CNT_W    = 16;
    localparam int IDX_W        = (DEF_NUM_VARS > 1) ? $clog2(DEF_NUM_VARS) : 1;

    // Encodings 15 and up are undefined and evaluate to r=0 (false).
    typedef enum logic [3:0] {
        ADD, SUB, MUL, AND, OR, XOR, NOTA, SHL, SHR, DIV, EQ, NE, LAND, LOR, LNOT
    } opcode_e;

    typedef struct packed {
        logic                 en;
        logic [3:0]           opcode;
        logic [IDX_W-1:0]     idx_a;
        logic [IDX_W-1:0]     idx_b;
        logic                 use_imm;
        logic [DEF_VAR_W-1:0] imm;
    } entry_t;

    typedef enum logic [1:0] {IDLE, EVAL, RESP} state_e;

endpackage

// File: rtl/constraint_alu.sv
// Evaluates one binary constraint: computes r = op(a, b) and reports whether r is non-zero.
// Latency: purely combinational.
// Backpressure: none; the result is consumed in the same cycle.
module constraint_alu
    import constraint_pkg::*;
#(
    parameter int VAR_W = DEF_VAR_W
) (
    input  logic [3:0]       opcode,
    input  logic [VAR_W-1:0] a,
    input  logic [VAR_W-1:0] b,
    output logic             is_true
);

    logic [VAR_W-1:0] r;

    always_comb begin
        r = '0;
        case (opcode)
            ADD:     r = a + b;
            SUB:     r = a - b;
            MUL:     r = a * b;
            AND:     r = a & b;
            OR:      r = a | b;
            XOR:     r = a ^ b;
            NOTA:    r = ~a;
            // Shift distances of VAR_W or more clear every bit.
            SHL:     if (b < VAR_W'(VAR_W)) r = a << b;
            SHR:     if (b < VAR_W'(VAR_W)) r = a >> b;
            DIV:     if (b != '0) r = a / b;
            EQ:      r[0] = (a == b);
            NE:      r[0] = (a != b);
            LAND:    r[0] = (a != '0) && (b != '0);
            LOR:     r[0] = (a != '0) || (b != '0);
            LNOT:    r[0] = (a == '0);
            default: r = '0;
        endcase
    end

    assign is_true = |r;

endmodule

// File: rtl/constraint_stream_checker.sv
// Checks each accepted candidate vector against a run-time loaded table of binary constraints.
// Latency: one entry per cycle, result NUM_CONS+1 cycles after accept (k+2 on early exit at entry k).
// Backpressure: one sample in flight; s_ready and cfg_ready stay low until the result is taken.
module constraint_stream_checker
    import constraint_pkg::*;
#(
    parameter int NUM_VARS = DEF_NUM_VARS,
    parameter int VAR_W    = DEF_VAR_W,
    parameter int NUM_CONS = DEF_NUM_CONS,
    parameter int CNT_W    = DEF_CNT_W,
    localparam int AW      = (NUM_CONS > 1) ? $clog2(NUM_CONS) : 1,
    localparam int FW      = $clog2(NUM_CONS + 1)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      cfg_we,
    output logic                      cfg_ready,
    input  logic [AW-1:0]             cfg_addr,
    input  entry_t                    cfg_entry,
    input  logic                      early_exit,
    input  logic                      s_valid,
    output logic                      s_ready,
    input  logic [NUM_VARS*VAR_W-1:0] s_vars,
    output logic                      m_valid,
    input  logic                      m_ready,
    output logic                      m_pass,
    output logic [AW-1:0]             m_first_fail,
    output logic [FW-1:0]             m_fail_cnt,
    input  logic                      stat_clr,
    output logic [CNT_W-1:0]          stat_samples,
    output logic [CNT_W-1:0]          stat_passes
);

    state_e                    state_q, state_d;
    entry_t                    tbl_q [NUM_CONS];
    logic [NUM_VARS*VAR_W-1:0] vars_q;
    logic                      early_q;
    logic [AW-1:0]             idx_q;
    logic                      pass_q;
    logic [AW-1:0]             first_q;
    logic [FW-1:0]             cnt_q;

    entry_t                    cur;
    logic [VAR_W-1:0]          op_a, op_b;
    logic                      alu_true, cur_fail, last_idx;

    function automatic logic [VAR_W-1:0] pick(input logic [NUM_VARS*VAR_W-1:0] v,
                                              input logic [IDX_W-1:0] i);
        pick = '0;
        if (int'(i) < NUM_VARS) pick = v[int'(i)*VAR_W +: VAR_W];
    endfunction

    always_comb begin
        cur  = tbl_q[idx_q];
        op_a = pick(vars_q, cur.idx_a);
        op_b = cur.use_imm ? cur.imm : pick(vars_q, cur.idx_b);
    end

    constraint_alu #(.VAR_W(VAR_W)) u_alu (
        .opcode  (cur.opcode),
        .a       (op_a),
        .b       (op_b),
        .is_true (alu_true)
    );

    // Disabled entries count as true but still take their cycle.
    assign cur_fail = cur.en & ~alu_true;
    assign last_idx = (idx_q == AW'(NUM_CONS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        s_ready   = 1'b0;
        cfg_ready = 1'b0;
        m_valid   = 1'b0;
        case (state_q)
            IDLE: begin
                s_ready   = 1'b1;
                cfg_ready = 1'b1;
                if (s_valid) state_d = EVAL;
            end
            EVAL: if ((cur_fail && early_q) || last_idx) state_d = RESP;
            RESP: begin
                m_valid = 1'b1;
                if (m_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // A write landing on the accept edge is visible to that sample's first EVAL cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CONS; i++) tbl_q[i] <= '0;
        end else if (cfg_we && state_q == IDLE && int'(cfg_addr) < NUM_CONS) begin
            tbl_q[cfg_addr] <= cfg_entry;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vars_q  <= '0;
            early_q <= 1'b0;
            idx_q   <= '0;
            pass_q  <= 1'b0;
            first_q <= '0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: if (s_valid) begin
                    vars_q  <= s_vars;
                    early_q <= early_exit;
                    idx_q   <= '0;
                    pass_q  <= 1'b1;
                    first_q <= '0;
                    cnt_q   <= '0;
                end
                EVAL: begin
                    if (!last_idx) idx_q <= idx_q + 1'b1;
                    if (cur_fail) begin
                        pass_q <= 1'b0;
                        cnt_q  <= cnt_q + 1'b1;
                        if (pass_q) first_q <= idx_q;
                    end
                end
                default: ;
            endcase
        end
    end

    assign m_pass       = pass_q;
    assign m_first_fail = first_q;
    assign m_fail_cnt   = cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_samples <= '0;
            stat_passes  <= '0;
        end else if (stat_clr) begin
            stat_samples <= '0;
            stat_passes  <= '0;
        end else if (m_valid && m_ready) begin
            if (stat_samples != '1) stat_samples <= stat_samples + 1'b1;
            if (m_pass && stat_passes != '1) stat_passes <= stat_passes + 1'b1;
        end
    end

endmodule

// File: tb/tb_constraint_stream_checker.sv
// Directed self-checking bench for constraint_stream_checker.
// Latency: n/a.
// Backpressure: exercised by holding m_ready low while the result is pending.
module tb_constraint_stream_checker;
    import constraint_pkg::*;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         cfg_we;
    logic         cfg_ready;
    logic [3:0]   cfg_addr;
    entry_t       cfg_entry;
    logic         early_exit;
    logic         s_valid;
    logic         s_ready;
    logic [127:0] s_vars;
    logic         m_valid;
    logic         m_ready;
    logic         m_pass;
    logic [3:0]   m_first_fail;
    logic [4:0]   m_fail_cnt;
    logic         stat_clr;
    logic [15:0]  stat_samples;
    logic [15:0]  stat_passes;

    int checks   = 0;
    int failures = 0;
    int es       = 0;
    int ep       = 0;

    typedef struct packed {
        logic [3:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic        ok;
    } vec_t;

    vec_t vecs [20] = '{
        '{ADD,  16'hFFFF, 16'h0001, 1'b0}, '{ADD,  16'h0001, 16'h0001, 1'b1},
        '{SUB,  16'h1234, 16'h1234, 1'b0}, '{MUL,  16'h0100, 16'h0100, 1'b0},
        '{MUL,  16'h0003, 16'h0005, 1'b1}, '{AND,  16'h00F0, 16'h000F, 1'b0},
        '{OR,   16'h0000, 16'h0000, 1'b0}, '{NOTA, 16'hFFFF, 16'h0000, 1'b0},
        '{SHL,  16'h8000, 16'h0001, 1'b0}, '{SHL,  16'h0001, 16'h000F, 1'b1},
        '{SHR,  16'h8000, 16'h000F, 1'b1}, '{DIV,  16'h0003, 16'h0004, 1'b0},
        '{EQ,   16'h0005, 16'h0005, 1'b1}, '{NE,   16'h0005, 16'h0005, 1'b0},
        '{LAND, 16'h0010, 16'h0000, 1'b0}, '{LOR,  16'h0000, 16'h0000, 1'b0},
        '{LNOT, 16'h0000, 16'h0000, 1'b1}, '{LNOT, 16'h0100, 16'h0000, 1'b0},
        '{4'hF, 16'h1234, 16'h5678, 1'b0}, '{SHL,  16'h0001, 16'h0010, 1'b0}
    };

    constraint_stream_checker dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cfg_we       (cfg_we),
        .cfg_ready    (cfg_ready),
        .cfg_addr     (cfg_addr),
        .cfg_entry    (cfg_entry),
        .early_exit   (early_exit),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .s_vars       (s_vars),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_pass       (m_pass),
        .m_first_fail (m_first_fail),
        .m_fail_cnt   (m_fail_cnt),
        .stat_clr     (stat_clr),
        .stat_samples (stat_samples),
        .stat_passes  (stat_passes)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic entry_t mk(input logic en, input logic [3:0] op, input int ia,
                                  input int ib, input logic ui, input logic [15:0] imm);
        entry_t e;
        e.en      = en;
        e.opcode  = op;
        e.idx_a   = IDX_W'(ia);
        e.idx_b   = IDX_W'(ib);
        e.use_imm = ui;
        e.imm     = imm;
        return e;
    endfunction

    function automatic logic [127:0] mkv(input logic [15:0] v0, input logic [15:0] v1,
                                         input logic [15:0] v3);
        return {64'h0, v3, 16'h0, v1, v0};
    endfunction

    task automatic wr(input int addr, input entry_t e);
        cfg_we    = 1'b1;
        cfg_addr  = 4'(addr);
        cfg_entry = e;
        @(posedge clk);
        #1;
        cfg_we    = 1'b0;
    endtask

    task automatic start(input logic [127:0] v, input logic ee);
        s_vars     = v;
        early_exit = ee;
        s_valid    = 1'b1;
        @(posedge clk);
        #1;
        s_valid    = 1'b0;
        cfg_we     = 1'b0;
    endtask

    task automatic finish(input string tag, input int exp_cyc, input logic exp_pass,
                          input int exp_ff, input int exp_fc, input int hold, input logic clr);
        int cyc;
        cyc = 1;
        while (!m_valid && cyc < 40) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk({tag, ".lat"},  cyc,          exp_cyc);
        chk({tag, ".pass"}, m_pass,       exp_pass);
        chk({tag, ".ff"},   m_first_fail, exp_ff);
        chk({tag, ".fc"},   m_fail_cnt,   exp_fc);
        chk({tag, ".srdy"}, s_ready,      0);
        chk({tag, ".crdy"}, cfg_ready,    0);
        if (hold > 0) begin
            cfg_we    = 1'b1;
            cfg_addr  = 4'd2;
            cfg_entry = mk(1'b0, ADD, 0, 0, 1'b0, 16'h0);
            s_valid   = 1'b1;
        end
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            chk({tag, ".hold_vld"},  m_valid,      1);
            chk({tag, ".hold_pass"}, m_pass,       exp_pass);
            chk({tag, ".hold_ff"},   m_first_fail, exp_ff);
            chk({tag, ".hold_fc"},   m_fail_cnt,   exp_fc);
            chk({tag, ".hold_srdy"}, s_ready,      0);
            chk({tag, ".hold_crdy"}, cfg_ready,    0);
        end
        cfg_we   = 1'b0;
        s_valid  = 1'b0;
        m_ready  = 1'b1;
        stat_clr = clr;
        @(posedge clk);
        #1;
        m_ready  = 1'b0;
        stat_clr = 1'b0;
        if (clr) begin
            es = 0;
            ep = 0;
        end else begin
            es++;
            if (exp_pass) ep++;
        end
        chk({tag, ".samples"}, stat_samples, es);
        chk({tag, ".passes"},  stat_passes,  ep);
        chk({tag, ".idle"},    m_valid,      0);
    endtask

    initial begin
        rst_n      = 1'b0;
        cfg_we     = 1'b0;
        cfg_addr   = '0;
        cfg_entry  = '0;
        early_exit = 1'b0;
        s_valid    = 1'b0;
        s_vars     = '0;
        m_ready    = 1'b0;
        stat_clr   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst.srdy",    s_ready,      1);
        chk("rst.crdy",    cfg_ready,    1);
        chk("rst.mvalid",  m_valid,      0);
        chk("rst.pass",    m_pass,       0);
        chk("rst.ff",      m_first_fail, 0);
        chk("rst.fc",      m_fail_cnt,   0);
        chk("rst.samples", stat_samples, 0);
        chk("rst.passes",  stat_passes,  0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Empty table passes everything.
        start(mkv(16'hABCD, 16'h1357, 16'h2468), 1'b0);
        finish("empty", 17, 1'b1, 0, 0, 0, 1'b0);

        wr(0, mk(1'b1, XOR, 0, 0, 1'b1, 16'h00F9));
        start(mkv(16'h00F9, 16'h0, 16'h0), 1'b0);
        finish("xor_eq", 17, 1'b0, 0, 1, 0, 1'b0);
        start(mkv(16'h00F8, 16'h0, 16'h0), 1'b0);
        finish("xor_ne", 17, 1'b1, 0, 0, 0, 1'b0);
        wr(0, mk(1'b0, XOR, 0, 0, 1'b1, 16'h00F9));

        wr(3, mk(1'b1, DIV, 3, 0, 1'b1, 16'h0000));
        start(mkv(16'h0, 16'h0, 16'h000D), 1'b0);
        finish("div0", 17, 1'b0, 3, 1, 0, 1'b0);
        wr(3, mk(1'b1, DIV, 3, 0, 1'b1, 16'h0004));
        start(mkv(16'h0, 16'h0, 16'h000D), 1'b0);
        finish("div4", 17, 1'b1, 0, 0, 0, 1'b0);
        wr(4, mk(1'b1, SHR, 1, 0, 1'b1, 16'h0010));
        start(mkv(16'h0, 16'hFFFF, 16'h000D), 1'b0);
        finish("shr16", 17, 1'b0, 4, 1, 0, 1'b0);
        start(mkv(16'h0, 16'hFFFF, 16'h0000), 1'b0);
        finish("div_shr", 17, 1'b0, 3, 2, 0, 1'b0);
        wr(3, mk(1'b0, DIV, 3, 0, 1'b1, 16'h0004));
        wr(4, mk(1'b0, SHR, 1, 0, 1'b1, 16'h0010));

        for (int i = 0; i < 20; i++) begin
            wr(0, mk(1'b1, vecs[i].op, 0, 0, 1'b1, vecs[i].b));
            start(mkv(vecs[i].a, 16'h0, 16'h0), 1'b0);
            finish($sformatf("alu%0d", i), 17, vecs[i].ok, 0, vecs[i].ok ? 0 : 1, 0, 1'b0);
        end

        // Operand b taken from a variable rather than the immediate.
        wr(0, mk(1'b1, SUB, 0, 1, 1'b0, 16'hFFFF));
        start(mkv(16'h1234, 16'h1234, 16'h0), 1'b0);
        finish("subv_eq", 17, 1'b0, 0, 1, 0, 1'b0);
        start(mkv(16'h1234, 16'h1233, 16'h0), 1'b0);
        finish("subv_ne", 17, 1'b1, 0, 0, 0, 1'b0);
        wr(0, mk(1'b0, SUB, 0, 1, 1'b0, 16'h0));

        wr(2, mk(1'b1, EQ,  0, 0, 1'b1, 16'h0001));
        wr(5, mk(1'b1, AND, 0, 0, 1'b1, 16'hFFFF));
        start(mkv(16'h0, 16'h0, 16'h0), 1'b1);
        finish("ee1", 4, 1'b0, 2, 1, 0, 1'b0);
        start(mkv(16'h0, 16'h0, 16'h0), 1'b0);
        finish("ee0_bp", 17, 1'b0, 2, 2, 5, 1'b0);
        start(mkv(16'h0, 16'h0, 16'h0), 1'b0);
        finish("readback", 17, 1'b0, 2, 2, 0, 1'b0);

        // Table write on the accept edge is seen by that sample.
        cfg_we    = 1'b1;
        cfg_addr  = 4'd2;
        cfg_entry = mk(1'b0, EQ, 0, 0, 1'b1, 16'h0001);
        start(mkv(16'h0, 16'h0, 16'h0), 1'b1);
        finish("wr_accept_clr", 7, 1'b0, 5, 1, 0, 1'b1);
        start(mkv(16'h0, 16'h0, 16'h0), 1'b0);
        finish("after_clr", 17, 1'b0, 5, 1, 0, 1'b0);

        start(mkv(16'h0, 16'h0, 16'h0), 1'b0);
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst.mvalid",  m_valid,      0);
        chk("midrst.srdy",    s_ready,      1);
        chk("midrst.fc",      m_fail_cnt,   0);
        chk("midrst.samples", stat_samples, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        es = 0;
        ep = 0;
        @(posedge clk);
        #1;
        start(mkv(16'h0, 16'h0, 16'h0), 1'b1);
        finish("post_rst", 17, 1'b1, 0, 0, 0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
